// File: rtl/pcg32_stream_checker.sv
// PCG32 stream checker: regenerates the XSH-RR PCG32 sequence from a loaded
// seed and compares every accepted beat against it, reporting mismatches,
// lock status and word/error counts.
module pcg32_stream_checker #(
    parameter logic [63:0] RESET_SEED = 64'h4d595df4d0f33173,
    parameter logic [63:0] MULT       = 64'd6364136223846793005,
    parameter logic [63:0] INC        = 64'd1442695040888963407,
    parameter int unsigned LOCK_RUN   = 4,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_seed,
    input  logic [63:0]          seed_in,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic                 in_ready,
    output logic [31:0]          expected,
    output logic                 mismatch,
    output logic                 locked,
    output logic [31:0]          word_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CHECK = 1'b1;
    localparam logic [7:0] LOCK_RUN_C = LOCK_RUN[7:0];

    logic [0:0]           fsm_q, fsm_d;
    logic [63:0]          state_q, state_d;
    logic                 mismatch_q, mismatch_d;
    logic                 locked_q, locked_d;
    logic [31:0]          word_q, word_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [7:0]           run_q, run_d;

    logic [63:0] xs;
    logic [63:0] xsh;
    logic [31:0] x;
    logic [4:0]  rot;
    logic [63:0] rot2;
    logic [31:0] exp_w;
    logic        beat;

    // XSH-RR output permutation of the current state; rotating the doubled
    // word keeps the rotate full-width with no zero-fill.
    always_comb begin
        xs    = (state_q >> 18) ^ state_q;
        xsh   = xs >> 27;
        x     = xsh[31:0];
        rot   = state_q[63:59];
        rot2  = {x, x} >> rot;
        exp_w = rot2[31:0];
    end

    // Control and counter next-state: load_seed beats stop beats a data beat.
    // in_ready is purely the registered FSM state, so no in_valid->in_ready path.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        mismatch_d = 1'b0;
        locked_d   = locked_q;
        word_d     = word_q;
        err_d      = err_q;
        run_d      = run_q;
        beat       = in_valid && (fsm_q == S_CHECK);

        if (load_seed) begin
            fsm_d    = S_CHECK;
            state_d  = seed_in;
            locked_d = 1'b0;
            word_d   = '0;
            err_d    = '0;
            run_d    = '0;
        end else if (fsm_q == S_CHECK) begin
            if (stop) begin
                // Concurrent beat is swallowed; counters and lock are held.
                fsm_d = S_IDLE;
            end else if (beat) begin
                state_d = state_q * MULT + INC;
                word_d  = word_q + 32'd1;
                if (in_data == exp_w) begin
                    if (run_q < LOCK_RUN_C)
                        run_d = run_q + 8'd1;
                    if (run_d == LOCK_RUN_C)
                        locked_d = 1'b1;
                end else begin
                    if (err_q != {ERR_CNT_W{1'b1}})
                        err_d = err_q + 1'b1;
                    run_d      = '0;
                    locked_d   = 1'b0;
                    mismatch_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= S_IDLE;
            state_q    <= RESET_SEED;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
            word_q     <= '0;
            err_q      <= '0;
            run_q      <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            locked_q   <= locked_d;
            word_q     <= word_d;
            err_q      <= err_d;
            run_q      <= run_d;
        end
    end

    assign in_ready   = (fsm_q == S_CHECK);
    assign expected   = exp_w;
    assign mismatch   = mismatch_q;
    assign locked     = locked_q;
    assign word_count = word_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_pcg32_stream_checker.sv
// Directed bench for pcg32_stream_checker. A reference PCG32 model (bitwise
// rotate) supplies stream words and expected values; a second instance with a
// 4-bit error counter covers counter saturation.
module tb_pcg32_stream_checker;

    localparam logic [63:0] SEED_A = 64'h4d595df4d0f33173;
    localparam logic [63:0] SEED_B = 64'h0123456789abcdef;
    localparam logic [63:0] M_MULT = 64'd6364136223846793005;
    localparam logic [63:0] M_INC  = 64'd1442695040888963407;

    logic        clk = 1'b0;
    logic        reset, load_seed, stop, in_valid;
    logic [63:0] seed_in;
    logic [31:0] in_data;

    logic        in_ready, mismatch, locked;
    logic [31:0] expected, word_count;
    logic [15:0] err_count;

    logic        in_ready4, mismatch4, locked4;
    logic [31:0] expected4, word_count4;
    logic [3:0]  err_count4;

    int errors = 0;
    int checks = 0;
    logic [63:0] mstate;
    logic [31:0] hold_exp;
    int pulses4;

    always #5 clk = ~clk;

    pcg32_stream_checker dut (
        .clk(clk), .reset(reset), .load_seed(load_seed), .seed_in(seed_in),
        .stop(stop), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .expected(expected), .mismatch(mismatch),
        .locked(locked), .word_count(word_count), .err_count(err_count)
    );

    pcg32_stream_checker #(.ERR_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .load_seed(load_seed), .seed_in(seed_in),
        .stop(stop), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .expected(expected4), .mismatch(mismatch4),
        .locked(locked4), .word_count(word_count4), .err_count(err_count4)
    );

    // Reference output: xorshift, then rotate right one bit at a time.
    function automatic logic [31:0] pcg_out(input logic [63:0] s);
        logic [31:0] v;
        int r;
        v = 32'(((s >> 18) ^ s) >> 27);
        r = int'(s[63:59]);
        for (int k = 0; k < r; k++) v = {v[0], v[31:1]};
        return v;
    endfunction

    function automatic logic [63:0] pcg_step(input logic [63:0] s);
        return s * M_MULT + M_INC;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        load_seed = 1'b1;
        seed_in   = s;
        tick();
        load_seed = 1'b0;
        mstate    = s;
    endtask

    initial begin
        reset = 1'b1; load_seed = 1'b0; stop = 1'b0; in_valid = 1'b0;
        seed_in = '0; in_data = '0;

        // 1. reset state and IDLE ignores in_valid
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mismatch", 64'(mismatch), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_expected", 64'(expected), 64'(pcg_out(SEED_A)));
        reset = 1'b0;
        in_valid = 1'b1; in_data = 32'hdeadbeef;
        tick(); tick();
        chk("idle_expected_hold", 64'(expected), 64'(pcg_out(SEED_A)));
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_word_count", 64'(word_count), 64'd0);
        in_valid = 1'b0;

        // 2. eight good words back-to-back, lock after the fourth
        do_load(SEED_A);
        chk("load_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_expected", 64'(expected), 64'(pcg_out(mstate)));
            in_valid = 1'b1; in_data = pcg_out(mstate);
            tick();
            mstate = pcg_step(mstate);
            chk("t2_mismatch", 64'(mismatch), 64'd0);
            chk("t2_locked", 64'(locked), 64'(i >= 3));
        end
        in_valid = 1'b0;
        chk("t2_word_count", 64'(word_count), 64'd8);
        chk("t2_err_count", 64'(err_count), 64'd0);

        // 3. beat 3 corrupted in bit 0
        do_load(SEED_A);
        chk("t3_reload_word_count", 64'(word_count), 64'd0);
        chk("t3_reload_locked", 64'(locked), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_expected", 64'(expected), 64'(pcg_out(mstate)));
            in_valid = 1'b1;
            in_data  = pcg_out(mstate) ^ ((i == 2) ? 32'd1 : 32'd0);
            tick();
            mstate = pcg_step(mstate);
            chk("t3_mismatch", 64'(mismatch), 64'(i == 2));
            chk("t3_locked", 64'(locked), 64'(i >= 6));
        end
        in_valid = 1'b0;
        chk("t3_err_count", 64'(err_count), 64'd1);
        chk("t3_word_count", 64'(word_count), 64'd8);

        // 4. in_valid every other cycle
        do_load(SEED_A);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            hold_exp = expected;
            tick();
            chk("t4_gap_expected", 64'(expected), 64'(hold_exp));
            chk("t4_gap_model", 64'(expected), 64'(pcg_out(mstate)));
            in_valid = 1'b1; in_data = pcg_out(mstate);
            tick();
            mstate = pcg_step(mstate);
            chk("t4_beat_expected", 64'(expected), 64'(pcg_out(mstate)));
            chk("t4_mismatch", 64'(mismatch), 64'd0);
        end
        in_valid = 1'b0;
        chk("t4_err_count", 64'(err_count), 64'd0);
        chk("t4_word_count", 64'(word_count), 64'd6);

        // 5. reseed with a concurrent beat, stop, then reset mid-stream
        do_load(SEED_A);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = pcg_out(mstate);
            tick();
            mstate = pcg_step(mstate);
        end
        chk("t5_pre_word_count", 64'(word_count), 64'd5);
        chk("t5_pre_locked", 64'(locked), 64'd1);
        in_valid = 1'b1; in_data = 32'h0badf00d;
        do_load(SEED_B);
        in_valid = 1'b0;
        chk("t5_word_count", 64'(word_count), 64'd0);
        chk("t5_err_count", 64'(err_count), 64'd0);
        chk("t5_locked", 64'(locked), 64'd0);
        chk("t5_mismatch", 64'(mismatch), 64'd0);
        chk("t5_expected_seed", 64'(expected), 64'(pcg_out(SEED_B)));
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = pcg_out(mstate);
            tick();
            mstate = pcg_step(mstate);
            chk("t5_b_mismatch", 64'(mismatch), 64'd0);
        end
        stop = 1'b1; in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        stop = 1'b0;
        chk("stop_in_ready", 64'(in_ready), 64'd0);
        chk("stop_word_count", 64'(word_count), 64'd2);
        chk("stop_err_count", 64'(err_count), 64'd0);
        chk("stop_mismatch", 64'(mismatch), 64'd0);
        chk("stop_expected", 64'(expected), 64'(pcg_out(mstate)));
        tick();
        chk("stop_idle_word_count", 64'(word_count), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t5_rst_word_count", 64'(word_count), 64'd0);
        chk("t5_rst_locked", 64'(locked), 64'd0);
        chk("t5_rst_expected", 64'(expected), 64'(pcg_out(SEED_A)));

        // 6. twenty corrupted words; narrow counter saturates at 15
        do_load(SEED_B);
        pulses4 = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = ~pcg_out(mstate);
            tick();
            mstate = pcg_step(mstate);
            if (mismatch4) pulses4++;
            chk("t6_locked", 64'(locked4), 64'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("t6_mismatch_clears", 64'(mismatch4), 64'd0);
        chk("t6_pulses", 64'(pulses4), 64'd20);
        chk("t6_err_count4", 64'(err_count4), 64'd15);
        chk("t6_err_count16", 64'(err_count), 64'd20);
        chk("t6_word_count", 64'(word_count4), 64'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
